mixcol_collect: RTL and testbench

- Byte-serial MixColumns front end for the 8-bit AES datapath.
- Collects four state bytes of one column, computes MixColumns on the column, and presents the 32-bit result to the downstream parallel-load/serial-unload byte shifter.
- Drives that shifter's `pdin` and `con_sel` directly; the shifter then emits the column highest byte first.
- Also tracks column position within the 128-bit block and supports a last-round bypass.

---
 rtl/mixcol_collect_if.sv | 53 +++++
 rtl/mixcol_collect.sv | 190 +++++++++++++++++++
 tb/tb_mixcol_collect.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mixcol_collect_if.sv
// -----------------------------------------------------------------------------
// mixcol_collect_if
//   Byte-in / column-out bundle between the ShiftRows/SubBytes stage, the
//   MixColumns collector and the downstream parallel-load byte shifter.
//
//   Optional feature macro: INV_MIXCOL_EN (adds the `dec` select line).
//
//   Signals
//     din       [7:0]        state byte from the upstream stage
//     din_valid              din carries a byte this cycle
//     bypass                 1 = final round, column passed through unmixed
//     col_clr                resync: discard partial column, zero counters
//     dec                    (INV_MIXCOL_EN only) 1 = InvMixColumns
//     pdin      [31:0]       completed column, [31:24] = first-received row
//     con_sel                one-cycle load strobe to the shifter
//     col_idx   [CNT_W-1:0]  column currently presented on pdin
//     last_col               high with con_sel for the last column of a block
//
//   Modports
//     master : upstream side (drives bytes and controls, observes results)
//     slave  : collector side (mixcol_collect)
// -----------------------------------------------------------------------------
interface mixcol_collect_if #(
  parameter int CNT_W = 2
);
  logic [7:0]       din;
  logic             din_valid;
  logic             bypass;
  logic             col_clr;
`ifdef INV_MIXCOL_EN
  logic             dec;
`endif
  logic [31:0]      pdin;
  logic             con_sel;
  logic [CNT_W-1:0] col_idx;
  logic             last_col;

  modport master (
`ifdef INV_MIXCOL_EN
    output dec,
`endif
    output din, din_valid, bypass, col_clr,
    input  pdin, con_sel, col_idx, last_col
  );

  modport slave (
`ifdef INV_MIXCOL_EN
    input  dec,
`endif
    input  din, din_valid, bypass, col_clr,
    output pdin, con_sel, col_idx, last_col
  );
endinterface

// File: rtl/mixcol_collect.sv
// -----------------------------------------------------------------------------
// mixcol_collect
//   Byte-serial MixColumns front end for the 8-bit AES datapath. Collects the
//   four bytes of one state column, then presents MixColumns(column) (or the
//   raw column in the final round) on pdin together with a one-cycle con_sel
//   load strobe for the downstream parallel-load/serial-unload shifter.
//   Tracks the column position within the 128-bit block.
//
//   Optional feature macro: INV_MIXCOL_EN
//     Defined   : bus.dec selects InvMixColumns {0e,0b,0d,09}, sampled with
//                 bypass at column completion. No extra latency.
//     Undefined : forward MixColumns only, no dec line.
//
//   Parameters
//     NCOLS : columns per AES block; col_idx wraps after NCOLS-1
//     CNT_W : width of col_idx (2**CNT_W >= NCOLS)
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset, clears every register
//     bus   : mixcol_collect_if.slave (byte input, column output, controls)
//
//   Timing
//     4th byte accepted at edge N -> con_sel = 1 and pdin valid in cycle N+1.
//     pdin holds until the next column completes. A new column may stream in
//     during the con_sel cycle (staging and output registers are separate).
// -----------------------------------------------------------------------------
module mixcol_collect #(
  parameter int NCOLS = 4,
  parameter int CNT_W = 2
) (
  input logic           clk,
  input logic           rst_n,
  mixcol_collect_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCOLS - 1);

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       bcnt;       // next slot to fill, 0 = row 0
  logic [23:0]      stage_q;    // rows 0..2 of the column being collected
  logic [31:0]      col_q;      // completed column a0..a3, a0 in [31:24]
  logic             byp_q;      // bypass sampled at completion
  logic             con_sel_q;
  logic             last_col_q;
  logic [CNT_W-1:0] col_idx_q;
`ifdef INV_MIXCOL_EN
  logic             dec_q;      // dec sampled at completion
`endif

  logic             complete;
  logic [CNT_W-1:0] col_idx_next;

  assign complete = bus.din_valid && (bcnt == 2'd3);

  // col_idx advances on the edge that ends a con_sel cycle, so during con_sel
  // it still names the column on pdin.
  always_comb begin
    col_idx_next = col_idx_q;
    if (con_sel_q)
      col_idx_next = (col_idx_q == LAST_IDX) ? '0 : col_idx_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the staging and column registers are reset like any other flop
      // because pdin must read 0 out of reset (MixColumns(0) = 0).
      bcnt       <= 2'd0;
      stage_q    <= '0;
      col_q      <= '0;
      byp_q      <= 1'b0;
      con_sel_q  <= 1'b0;
      last_col_q <= 1'b0;
      col_idx_q  <= '0;
`ifdef INV_MIXCOL_EN
      dec_q      <= 1'b0;
`endif
    end else if (bus.col_clr) begin
      // Resync wins over completion; an incoming byte is dropped and the
      // presented column stays on pdin.
      bcnt       <= 2'd0;
      con_sel_q  <= 1'b0;
      last_col_q <= 1'b0;
      col_idx_q  <= '0;
    end else begin
      con_sel_q  <= complete;
      last_col_q <= complete && (col_idx_next == LAST_IDX);
      col_idx_q  <= col_idx_next;
      if (bus.din_valid) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0:    stage_q[23:16] <= bus.din;
          2'd1:    stage_q[15:8]  <= bus.din;
          2'd2:    stage_q[7:0]   <= bus.din;
          default: begin
            // 4th byte bypasses staging and goes straight into the output
            // column together with rows 0..2.
            col_q <= {stage_q, bus.din};
            byp_q <= bus.bypass;
`ifdef INV_MIXCOL_EN
            dec_q <= bus.dec;
`endif
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Column transform, combinational from the output register
  // ---------------------------------------------------------------------------
  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] fwd_col;
  logic [31:0] mix_col;
  logic [31:0] pdin_c;

  assign a0 = col_q[31:24];
  assign a1 = col_q[23:16];
  assign a2 = col_q[15:8];
  assign a3 = col_q[7:0];

  assign fwd_col = {xtime(a0) ^ mul3(a1)  ^ a2        ^ a3,
                    a0        ^ xtime(a1) ^ mul3(a2)  ^ a3,
                    a0        ^ a1        ^ xtime(a2) ^ mul3(a3),
                    mul3(a0)  ^ a1        ^ a2        ^ xtime(a3)};

`ifdef INV_MIXCOL_EN
  // Inverse coefficients from the x, 2x, 4x, 8x xtime chain:
  //   9 = 8^1, b = 8^2^1, d = 8^4^1, e = 8^4^2
  logic [7:0] m2 [4];
  logic [7:0] m4 [4];
  logic [7:0] m8 [4];
  logic [7:0] av [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [31:0] inv_col;

  always_comb begin
    av = '{a0, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      m2[i] = xtime(av[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      m9[i] = m8[i] ^ av[i];
      mb[i] = m8[i] ^ m2[i] ^ av[i];
      md[i] = m8[i] ^ m4[i] ^ av[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    inv_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  end

  assign mix_col = dec_q ? inv_col : fwd_col;
`else
  assign mix_col = fwd_col;
`endif

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    pdin_c = mix_col;
    if (byp_q)
      pdin_c = col_q;
  end

  assign bus.pdin     = pdin_c;
  assign bus.con_sel  = con_sel_q;
  assign bus.col_idx  = col_idx_q;
  assign bus.last_col = last_col_q;

endmodule

// File: tb/tb_mixcol_collect.sv
// -----------------------------------------------------------------------------
// tb_mixcol_collect
//   Directed and randomized checks of mixcol_collect against a reference that
//   multiplies the column by the (Inv)MixColumns matrix with a generic GF(2^8)
//   multiply. Inputs change 1 ns after a rising edge; outputs are checked at
//   that point, i.e. they reflect the preceding edge.
// -----------------------------------------------------------------------------
module tb_mixcol_collect;

  localparam int NCOLS = 4;
  localparam int CNT_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mixcol_collect_if #(.CNT_W(CNT_W)) bus ();

  mixcol_collect #(.NCOLS(NCOLS), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix: row r, column c uses base[(c - r) mod 4].
  function automatic logic [31:0] ref_col(input logic [31:0] w, input logic byp,
                                          input logic inv);
    logic [7:0]  col [4];
    logic [7:0]  base [4];
    logic [7:0]  acc;
    logic [31:0] res = '0;
    if (byp) return w;
    for (int c = 0; c < 4; c++) col[c] = w[31 - 8*c -: 8];
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int c = 0; c < 4; c++) acc = acc ^ gmul(base[(c - r + 4) % 4], col[c]);
      res[31 - 8*r -: 8] = acc;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] b);
    bus.din       = b;
    bus.din_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_strobe(input string tag, input logic [31:0] exp_pdin,
                              input int exp_idx, input logic exp_last);
    check({tag, " con_sel"},  {31'd0, bus.con_sel},  32'd1);
    check({tag, " pdin"},     bus.pdin,              exp_pdin);
    check({tag, " col_idx"},  {30'd0, bus.col_idx},  32'(exp_idx));
    check({tag, " last_col"}, {31'd0, bus.last_col}, {31'd0, exp_last});
  endtask

  // Four consecutive bytes; no strobe may appear before the 4th.
  task automatic send_col(input string tag, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      feed(w[31 - 8*b -: 8]);
      if (b < 3) check({tag, " no early con_sel"}, {31'd0, bus.con_sel}, 32'd0);
    end
  endtask

  logic [31:0] exp_pdin;
  logic [31:0] w;
  logic        byp, inv;
  int          col_count;
  int          gap;

  initial begin
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    bus.bypass    = 1'b0;
    bus.col_clr   = 1'b0;
`ifdef INV_MIXCOL_EN
    bus.dec       = 1'b0;
`endif

    // ---- reset then idle ----------------------------------------------------
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("reset pdin",     bus.pdin,              32'h0);
      check("reset con_sel",  {31'd0, bus.con_sel},  32'd0);
      check("reset col_idx",  {30'd0, bus.col_idx},  32'd0);
      check("reset last_col", {31'd0, bus.last_col}, 32'd0);
      tick();
    end

    // ---- single column ------------------------------------------------------
    send_col("single", 32'hdb135345);
    check_strobe("single", 32'h8e4da1bc, 0, 1'b0);
    idle(1);
    check("single strobe one cycle", {31'd0, bus.con_sel}, 32'd0);
    check("single col_idx advance",  {30'd0, bus.col_idx}, 32'd1);
    idle(10);
    check("single pdin held", bus.pdin, 32'h8e4da1bc);

    // col_clr zeroes the column counter but keeps the presented column.
    bus.col_clr = 1'b1;
    idle(1);
    bus.col_clr = 1'b0;
    check("clr col_idx",   {30'd0, bus.col_idx}, 32'd0);
    check("clr pdin kept", bus.pdin,             32'h8e4da1bc);

    // ---- back-to-back with one gap, full block, wrap ------------------------
    send_col("b2b0", 32'hf20a225c);
    check_strobe("b2b0", 32'h9fdc589d, 0, 1'b0);
    idle(1);
    send_col("b2b1", 32'h01010101);
    check_strobe("b2b1", 32'h01010101, 1, 1'b0);
    send_col("b2b2", 32'hc6c6c6c6);
    check_strobe("b2b2", 32'hc6c6c6c6, 2, 1'b0);
    send_col("b2b3", 32'h2d26314c);
    check_strobe("b2b3", 32'h4d7ebdf8, 3, 1'b1);
    idle(1);
    check("b2b wrap col_idx", {30'd0, bus.col_idx},  32'd0);
    check("b2b last_col off", {31'd0, bus.last_col}, 32'd0);

    // ---- bypass -------------------------------------------------------------
    bus.bypass = 1'b1;
    send_col("bypass", 32'hdb135345);
    check_strobe("bypass", 32'hdb135345, 0, 1'b0);
    bus.bypass = 1'b0;
    idle(3);
    check("bypass toggle after capture", bus.pdin, 32'hdb135345);

    // ---- resync with col_clr ------------------------------------------------
    bus.col_clr = 1'b1;
    idle(1);
    bus.col_clr = 1'b0;
    feed(8'hdb);
    feed(8'h13);
    bus.col_clr = 1'b1;
    feed(8'h53);              // dropped
    bus.col_clr = 1'b0;
    check("resync no con_sel", {31'd0, bus.con_sel}, 32'd0);
    check("resync col_idx",    {30'd0, bus.col_idx}, 32'd0);
    send_col("resync", 32'hf20a225c);
    check_strobe("resync", 32'h9fdc589d, 0, 1'b0);
    idle(1);

    // col_clr coinciding with the 4th byte suppresses the completion.
    bus.col_clr = 1'b1;
    idle(1);
    bus.col_clr = 1'b0;
    feed(8'h01);
    feed(8'h02);
    feed(8'h03);
    bus.col_clr = 1'b1;
    feed(8'h04);
    bus.col_clr = 1'b0;
    check("clr beats completion con_sel", {31'd0, bus.con_sel}, 32'd0);
    check("clr beats completion pdin",    bus.pdin,             32'h9fdc589d);

    // ---- reset mid-column ---------------------------------------------------
    feed(8'h11);
    feed(8'h22);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("rst mid pdin",    bus.pdin,             32'h0);
    check("rst mid con_sel", {31'd0, bus.con_sel}, 32'd0);
    feed(8'h33);
    feed(8'h44);
    check("rst partial lost", {31'd0, bus.con_sel}, 32'd0);
    feed(8'h55);
    feed(8'h66);
    check_strobe("rst fresh col", ref_col(32'h33445566, 1'b0, 1'b0), 0, 1'b0);
    idle(1);

`ifdef INV_MIXCOL_EN
    // ---- inverse MixColumns -------------------------------------------------
    bus.dec = 1'b1;
    send_col("inv", 32'h8e4da1bc);
    check_strobe("inv", 32'hdb135345, 1, 1'b0);
    bus.dec = 1'b0;
    send_col("inv fwd", 32'h8e4da1bc);
    check_strobe("inv fwd", ref_col(32'h8e4da1bc, 1'b0, 1'b0), 2, 1'b0);
    idle(1);
`endif

    // ---- randomized columns with gaps ---------------------------------------
    bus.col_clr = 1'b1;
    idle(1);
    bus.col_clr = 1'b0;
    exp_pdin  = bus.pdin === 32'hx ? 32'h0 : ref_col(32'h33445566, 1'b0, 1'b0);
`ifdef INV_MIXCOL_EN
    exp_pdin  = ref_col(32'h8e4da1bc, 1'b0, 1'b0);
`endif
    col_count = 0;
    for (int n = 0; n < 24; n++) begin
      w   = $urandom;
      byp = ($urandom_range(0, 3) == 0);
      inv = 1'b0;
`ifdef INV_MIXCOL_EN
      inv = 1'($urandom_range(0, 1));
`endif
      for (int b = 0; b < 4; b++) begin
        // Only the value at the 4th byte matters; scramble the others.
        bus.bypass = (b == 3) ? byp : 1'($urandom_range(0, 1));
`ifdef INV_MIXCOL_EN
        bus.dec    = (b == 3) ? inv : 1'($urandom_range(0, 1));
`endif
        feed(w[31 - 8*b -: 8]);
        if (b < 3) begin
          check($sformatf("rnd%0d b%0d no con_sel", n, b), {31'd0, bus.con_sel}, 32'd0);
          check($sformatf("rnd%0d b%0d pdin held", n, b), bus.pdin, exp_pdin);
          gap = $urandom_range(0, 2);
          if (gap > 0) idle(gap);
        end
      end
      exp_pdin = ref_col(w, byp, inv);
      check_strobe($sformatf("rnd%0d", n), exp_pdin, col_count % NCOLS,
                   (col_count % NCOLS) == NCOLS - 1);
      col_count++;
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
